bram_stream_reader: RTL and testbench

Read-side master for the 1024 x 8 simple dual-port block RAM. On a `start` command it walks a contiguous address range, issues one read per cycle into the RAM's registered read port (1-cycle latency), and presents the returned bytes as a valid/ready byte stream with full backpressure support. It sits between the RAM's read port and any byte consumer, such as a UART TX or a checksum unit.

---
 rtl/bram_stream_reader_if.sv | 34 +++
 rtl/bram_stream_reader.sv | 160 ++++++++++++++++
 tb/tb_bram_stream_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Bundle of the command/status, RAM read-port and byte-stream signals of bram_stream_reader.
// The master modport is the reader itself; the slave modport is its environment (commander, RAM, consumer).
interface bram_stream_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              busy;
    logic              done;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Stream handshake: a byte moves on every rising edge where out_valid && out_ready;
    // once out_valid is high, out_data/out_last hold until that transfer (or an abort/reset).
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        input  start, start_addr, length, abort, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, start_addr, length, abort, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks a contiguous (wrapping) RAM address range, one read per cycle into a 1-cycle-latency port,
// and re-times the returned bytes through a 2-entry FIFO into a valid/ready byte stream.
module bram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_stream_reader_if.master  bus,
    output logic [1:0]            o_state,
    output logic [1:0]            o_occ
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;
    logic              w_done_next;

    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    logic              w_start_ok;
    logic              w_abort;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [2:0]        w_occ_after;
    logic [ADDR_W:0]   w_len_clamped;

    assign w_len_clamped = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;
    assign w_start_ok    = (r_state == S_IDLE) && bus.start;
    assign w_abort       = bus.abort && (r_state != S_IDLE);
    assign w_pop         = (r_occ != 2'd0) && bus.out_ready;
    assign w_push        = r_inflight && !w_abort;

    // Occupancy once this cycle's landing read and pop are accounted for; a new read is only
    // issued if its byte is guaranteed a FIFO slot when it lands.
    assign w_occ_after   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue       = (r_state == S_RUN) && (r_remaining != '0) && !bus.abort
                           && (w_occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (r_remaining == '0) begin
                    w_state_next = S_DRAIN;
                end else if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (!r_inflight && (w_occ_after == 3'd0)) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= w_done_next;
            r_inflight <= w_issue;
            if (w_start_ok && (bus.length != '0)) begin
                r_addr      <= bus.start_addr;
                r_remaining <= w_len_clamped;
            end else if (w_issue) begin
                r_addr          <= r_addr + ADDR_W'(1);
                r_remaining     <= r_remaining - (ADDR_W+1)'(1);
                r_inflight_last <= (r_remaining == (ADDR_W+1)'(1));
            end
        end
    end

    // An abort flushes the FIFO and drops the read landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_occ          <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.rd_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= w_occ_after[1:0];
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.rd_en     = w_issue;
    assign bus.rd_addr   = r_addr;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_fifo_data[r_rd_ptr];
    assign bus.out_last  = r_fifo_last[r_rd_ptr];

    assign o_state = r_state;
    assign o_occ   = r_occ;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised and directed bench for bram_stream_reader: a RAM model feeds the read port, expected
// bytes are derived from the RAM contents and pushed into a queue, a negedge monitor pops and compares.
module tb_bram_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic [1:0] dbg_occ;

    bram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state),
        .o_occ   (dbg_occ)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DATA_W:0] exp_q [$];
    int addr_log [$];
    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt, hs_cnt, done_cnt, first_hs, last_hs;
    int ready_mode = 0;
    int ready_ph = 0;
    bit prev_stall = 1'b0;
    logic [DATA_W:0] prev_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, prev_byte});
            end
            if (bus.rd_en) begin
                rd_cnt++;
                addr_log.push_back(int'(bus.rd_addr));
            end
            if (bus.done) done_cnt++;
            check("occ_le_2", {31'd0, (dbg_occ <= 2'd2)}, 32'd1);
            if (bus.out_valid && bus.out_ready) begin
                if (first_hs < 0) first_hs = cyc;
                if (bus.out_last) last_hs = cyc;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, bus.out_last, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_q.pop_front()});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
            prev_byte  = {bus.out_last, bus.out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- consumer ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: case (ready_ph % 4)
                       0, 3:    bus.out_ready = 1'b1;
                       default: bus.out_ready = 1'b0;
                   endcase
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            ready_ph++;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after start was presented.
    task automatic issue_start(input int addr, input int len, output int c0, output int eff);
        eff = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < eff; k++)
            exp_q.push_back({(k == eff - 1), mem[(addr + k) % DEPTH]});
        rd_cnt = 0;
        hs_cnt = 0;
        first_hs = -1;
        last_hs = -1;
        addr_log.delete();
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(addr);
        bus.length     = (ADDR_W+1)'(len);
        c0 = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (eff > 0) begin
            check("c1_busy", {31'd0, bus.busy}, 32'd1);
            check("c1_rd_en", {31'd0, bus.rd_en}, 32'd1);
            check("c1_rd_addr", {22'd0, bus.rd_addr}, 32'(addr % DEPTH));
        end else begin
            check("len0_busy", {31'd0, bus.busy}, 32'd0);
            check("len0_rd_en", {31'd0, bus.rd_en}, 32'd0);
        end
    endtask

    // Returns at posedge+1 of the done cycle, so a following start is back-to-back.
    task automatic finish_xfer(input int c0, input int eff, input bit chk_time);
        int n = 0;
        while (!bus.done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", {31'd0, bus.done}, 32'd1);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("rd_count", 32'(rd_cnt), 32'(eff));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        if (chk_time) begin
            check("done_cycle", 32'(cyc), (eff == 0) ? 32'(c0 + 1) : 32'(c0 + eff + 3));
            if (eff > 0) begin
                check("first_byte_cycle", 32'(first_hs), 32'(c0 + 3));
                check("last_byte_cycle", 32'(last_hs), 32'(c0 + eff + 2));
            end
        end
        exp_q.delete();
    endtask

    task automatic run_xfer(input int addr, input int len, input int mode, input bit chk_time);
        int c0, eff;
        ready_mode = mode;
        issue_start(addr, len, c0, eff);
        finish_xfer(c0, eff, chk_time);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, eff, d0, n;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.length = '0;
        bus.abort = 1'b0;
        bus.rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
        check("rst_rd_addr", {22'd0, bus.rd_addr}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_occ", {30'd0, dbg_occ}, 32'd0);

        // Streaming, wrap-around, backpressure, edge lengths
        run_xfer(5, 4, 0, 1);
        run_xfer(1022, 4, 0, 1);
        check("wrap_addr_count", 32'(addr_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check("wrap_addr", 32'(addr_log[k]), 32'((1022 + k) % DEPTH));
        run_xfer(1020, 8, 0, 1);
        run_xfer(40, 16, 1, 0);
        run_xfer(77, 0, 0, 1);
        run_xfer(333, 2000, 0, 1);

        // Abort after three bytes with a read in flight
        ready_mode = 0;
        issue_start(200, 10, c0, eff);
        n = 0;
        while (hs_cnt < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reached_3", {31'd0, (hs_cnt >= 3)}, 32'd1);
        d0 = done_cnt;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        exp_q.delete();
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        run_xfer(0, 1, 0, 1);

        // Reset mid-transfer
        ready_mode = 0;
        issue_start(300, 20, c0, eff);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        check("mrst_rd_en", {31'd0, bus.rd_en}, 32'd0);
        check("mrst_rd_addr", {22'd0, bus.rd_addr}, 32'd0);
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("mrst_out_last", {31'd0, bus.out_last}, 32'd0);

        // Start while busy is ignored; the original range completes on time
        ready_mode = 0;
        issue_start(100, 12, c0, eff);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.start_addr = ADDR_W'(500);
        bus.length = (ADDR_W+1)'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish_xfer(c0, eff, 1);

        // Back-to-back: second start issued in the done cycle of the first
        run_xfer(10, 3, 0, 1);
        run_xfer(20, 2, 0, 1);

        // Random contents, ranges and consumer behaviour
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        for (int t = 0; t < 14; t++) begin
            int a, l, m;
            a = $urandom_range(0, DEPTH - 1);
            l = (t == 5) ? 0 : $urandom_range(1, 48);
            m = $urandom_range(0, 2);
            run_xfer(a, l, m, (m == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
